mod_counter: RTL



---
 rtl/mod_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_counter                                                     |
// | Desc     : Parametrised modulo up/down counter with wrap/saturate mode,    |
// |            parallel load, registered boundary pulse and optional sticky    |
// |            overflow flag (enabled by defining MOD_COUNTER_STICKY_OVF_EN).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mod_counter #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX      = (2**WIDTH) - 1,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned INIT     = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] O,
    output logic             at_max,
    output logic             at_zero,
    output logic             tc_evt,
    output logic             ovf
);

    // Boundary arithmetic is carried one bit wider so O + STEP cannot overflow.
    localparam logic [WIDTH:0]   c_max_x  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   c_mod_x  = (WIDTH+1)'(MAX + 1);
    localparam logic [WIDTH:0]   c_step_x = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] c_max_w  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_step_w = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_init_w = WIDTH'(INIT);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_sum;
    logic             w_up_bnd;
    logic             w_dn_bnd;
    logic             w_bnd;
    logic [WIDTH-1:0] w_up_lim;
    logic [WIDTH-1:0] w_dn_lim;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_ld_val;

    assign w_cnt_x  = {1'b0, r_count};
    assign w_sum    = w_cnt_x + c_step_x;
    assign w_up_bnd = (w_sum > c_max_x);
    assign w_dn_bnd = (w_cnt_x < c_step_x);
    assign w_bnd    = up ? w_up_bnd : w_dn_bnd;

    // Out-of-range load values clamp to MAX rather than aliasing.
    assign w_ld_val = ({1'b0, load_value} > c_max_x) ? c_max_w : load_value;

    generate
        if (SATURATE != 0) begin : g_sat
            assign w_up_lim = c_max_w;
            assign w_dn_lim = '0;
        end else begin : g_wrap
            assign w_up_lim = WIDTH'(w_sum - c_mod_x);
            assign w_dn_lim = WIDTH'(w_cnt_x + c_mod_x - c_step_x);
        end
    endgenerate

    always_comb begin
        w_step_val = r_count;
        if (up) begin
            w_step_val = w_up_bnd ? w_up_lim : WIDTH'(w_sum);
        end else begin
            w_step_val = w_dn_bnd ? w_dn_lim : (r_count - c_step_w);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= c_init_w;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_ld_val;
            r_tc    <= 1'b0;
        end else if (en) begin
            r_count <= w_step_val;
            r_tc    <= w_bnd;
        end else begin
            r_tc    <= 1'b0;
        end
    end

`ifdef MOD_COUNTER_STICKY_OVF_EN
    logic w_evt;
    logic r_ovf;

    assign w_evt = en & ~load & w_bnd;

    // A new event takes precedence over a coincident clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ovf <= 1'b0;
        end else if (w_evt) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = ovf_clr;
    assign ovf              = 1'b0;
`endif

    assign O       = r_count;
    assign tc_evt  = r_tc;
    assign at_max  = (r_count == c_max_w);
    assign at_zero = (r_count == '0);

endmodule
`default_nettype wire
